// File: rtl/seq_shift_add_multiplier.sv
// rtl/seq_shift_add_multiplier.sv - sequential shift-and-add multiplier, signed/unsigned, fixed WIDTH+1 latency
//
// Purpose: multiplies two WIDTH-bit operands, one radix-2 step per clock.
// The multiplier works on magnitudes and applies the sign in a final fix-up
// cycle. Latency is always WIDTH+1 cycles from the Start edge to Done.
//
// Ports:
//   Clk       clock, rising edge
//   Reset     synchronous, active-high; abandons any operation in flight
//   Start     request; sampled only while Busy=0
//   SignedOp  1 = two's-complement operands, 0 = unsigned; sampled with Start
//   A         multiplicand (WIDTH bits); sampled with Start
//   B         multiplier (WIDTH bits); sampled with Start
//   Product   2*WIDTH-bit result register; holds until the next Done
//   Busy      high while an operation is in flight
//   Done      one-cycle pulse; Product is valid in the same cycle

module seq_shift_add_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Start,
  input  logic                 SignedOp,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic [2*WIDTH-1:0]   Product,
  output logic                 Busy,
  output logic                 Done
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t               state_q;
  logic [WIDTH-1:0]     mcand_q;
  logic [WIDTH-1:0]     mplier_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 neg_q;
  logic [2*WIDTH-1:0]   product_q;
  logic                 busy_q;
  logic                 done_q;

  logic [WIDTH-1:0]     a_mag_d;
  logic [WIDTH-1:0]     b_mag_d;
  logic                 neg_d;
  logic [WIDTH-1:0]     addend_d;
  logic [WIDTH:0]       sum_d;
  logic [2*WIDTH-1:0]   product_d;

  always_comb begin
    // -2^(WIDTH-1) negates to itself, which read as unsigned is the correct magnitude.
    a_mag_d   = (SignedOp && A[WIDTH-1]) ? -A : A;
    b_mag_d   = (SignedOp && B[WIDTH-1]) ? -B : B;
    neg_d     = SignedOp & (A[WIDTH-1] ^ B[WIDTH-1]);
    addend_d  = mplier_q[0] ? mcand_q : '0;
    // Keep the carry out of the upper half; it becomes the new MSB after the shift.
    sum_d     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend_d};
    // A zero magnitude negates to zero, so a negative sign on a zero result is harmless.
    product_d = neg_q ? -acc_q : acc_q;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (Start) begin
            mcand_q  <= a_mag_d;
            mplier_q <= b_mag_d;
            neg_q    <= neg_d;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= S_RUN;
          end
        end
        S_RUN: begin
          acc_q    <= {sum_d, acc_q[WIDTH-1:1]};
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == LAST_ITER) begin
            state_q <= S_FIX;
          end
        end
        S_FIX: begin
          product_q <= product_d;
          done_q    <= 1'b1;
          busy_q    <= 1'b0;
          state_q   <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign Product = product_q;
  assign Busy    = busy_q;
  assign Done    = done_q;

endmodule
